// File: rtl/mtm_alu_deserializer.sv
// mtm_alu_deserializer: decodes 11-bit serial frames into one {A,B,op} request or an error pulse
module mtm_alu_deserializer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic        out_valid,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [2:0]  op_out,
    output logic        err_valid,
    output logic [2:0]  err_flags
);
    typedef enum logic [1:0] {IDLE, RX, CHK} state_t;
    state_t      state;
    logic [3:0]  bit_cnt, byte_cnt, crc, crc_nxt;
    logic [7:0]  sh;
    logic [31:0] a_sh, b_sh;
    logic        typ, ovf, crc_en, crc_bit;
    // CRC runs serially over data bits, then over the CTL frame's implicit 1 and its opcode
    always_comb begin
        crc_en  = state == RX && bit_cnt != 4'd0 && bit_cnt != 4'd9 && (typ ? bit_cnt <= 4'd4 : byte_cnt < 4'd8);
        crc_bit = (typ && bit_cnt == 4'd1) ? 1'b1 : sin;
        crc_nxt = {crc[2:0], 1'b0} ^ ((crc[3] ^ crc_bit) ? 4'b0011 : 4'b0000);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            crc       <= '0;
            sh        <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            typ       <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            err_valid <= 1'b0;
            err_flags <= '0;
            a_out     <= '0;
            b_out     <= '0;
            op_out    <= '0;
        end else begin
            out_valid <= 1'b0;
            err_valid <= 1'b0;
            if (crc_en) crc <= crc_nxt;
            case (state)
                IDLE, CHK: begin
                    state   <= sin ? IDLE : RX;
                    bit_cnt <= '0;
                end
                RX: begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd0) typ <= sin;
                    if (bit_cnt != 4'd0 && bit_cnt != 4'd9) sh <= {sh[6:0], sin};
                    if (bit_cnt == 4'd9) begin
                        state <= CHK;
                        if (!sin || typ) begin
                            byte_cnt <= '0;
                            ovf      <= 1'b0;
                            crc      <= '0;
                        end
                        if (!sin) begin
                            err_valid <= 1'b1;
                            err_flags <= 3'b100;
                        end else if (!typ) begin
                            if (byte_cnt == 4'd8) ovf <= 1'b1;
                            else begin
                                byte_cnt <= byte_cnt + 4'd1;
                                if (byte_cnt[2]) a_sh[{~byte_cnt[1:0], 3'b000} +: 8] <= sh;
                                else b_sh[{~byte_cnt[1:0], 3'b000} +: 8] <= sh;
                            end
                        end else if (byte_cnt != 4'd8 || ovf) begin
                            err_valid <= 1'b1;
                            err_flags <= 3'b100;
                        end else if (sh[3:0] != crc) begin
                            err_valid <= 1'b1;
                            err_flags <= 3'b010;
                        end else if (sh[5]) begin
                            err_valid <= 1'b1;
                            err_flags <= 3'b001;
                        end else begin
                            out_valid <= 1'b1;
                            a_out     <= a_sh;
                            b_out     <= b_sh;
                            op_out    <= sh[6:4];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// tb_mtm_alu_deserializer: vector table, corner sequences and random packets against a packet-level model
module tb_mtm_alu_deserializer;
    logic        clk = 1'b0, rst_n = 1'b0, sin = 1'b1;
    logic        out_valid, err_valid;
    logic [31:0] a_out, b_out;
    logic [2:0]  op_out, err_flags;
    int n_chk = 0, n_fail = 0, pulses = 0, exp_pulses = 0;
    logic [31:0] last_a = '0, last_b = '0;
    logic [2:0]  last_op = '0;

    mtm_alu_deserializer dut (
        .clk(clk), .rst_n(rst_n), .sin(sin), .out_valid(out_valid), .a_out(a_out),
        .b_out(b_out), .op_out(op_out), .err_valid(err_valid), .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] b;
        logic [31:0] a;
        logic [2:0]  op;
        logic [3:0]  crc;
        int          nd;
        logic        ev;
        logic [2:0]  ef;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // CRC as remainder of polynomial division of {msg, 4'b0} by x^4+x+1
    function automatic logic [3:0] crc_model(input logic [67:0] msg);
        logic [71:0] r;
        r = {msg, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    function automatic void model(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                                  input logic [3:0] crc, input int nd, output logic ev, output logic [2:0] ef);
        ev = 1'b0;
        ef = 3'b000;
        if (nd != 8) ef = 3'b100;
        else if (crc != crc_model({b, a, 1'b1, op})) ef = 3'b010;
        else if (!(op inside {3'b000, 3'b001, 3'b100, 3'b101})) ef = 3'b001;
        else ev = 1'b1;
    endfunction

    always @(negedge clk)
        if (rst_n && (out_valid || err_valid)) begin
            pulses++;
            chk("exclusive", {63'b0, out_valid & err_valid}, 64'd0);
        end

    task automatic send_bit(input logic v);
        @(negedge clk);
        sin = v;
    endtask

    task automatic send_frame(input logic typ, input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        send_bit(typ);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic send_pkt(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                            input logic [3:0] crc, input int nd, input int gmax);
        logic [63:0] ba;
        ba = {b, a};
        for (int k = 0; k < nd; k++) begin
            send_frame(1'b0, k < 8 ? ba[63 - 8*k -: 8] : 8'hA5, 1'b1);
            repeat ($urandom_range(0, gmax)) send_bit(1'b1);
        end
        send_frame(1'b1, {1'b0, op, crc}, 1'b1);
    endtask

    task automatic check_pkt(input logic ev, input logic [2:0] ef, input logic [31:0] b,
                             input logic [31:0] a, input logic [2:0] op);
        @(negedge clk);
        sin = 1'b1;
        exp_pulses++;
        chk("out_valid", out_valid, ev);
        chk("err_valid", err_valid, !ev);
        if (ev) begin
            last_a = a;
            last_b = b;
            last_op = op;
        end else chk("err_flags", err_flags, ef);
        chk("a_out", a_out, last_a);
        chk("b_out", b_out, last_b);
        chk("op_out", op_out, last_op);
        @(negedge clk);
        chk("pulse_width", {out_valid, err_valid}, 64'd0);
    endtask

    initial begin
        logic [31:0] rb, ra;
        logic [2:0]  rop;
        logic [3:0]  rcrc;
        int          rnd, mode;
        logic        ev;
        logic [2:0]  ef;
        tbl[0] = '{32'h0, 32'h0, 3'b000, 4'hB, 8, 1'b1, 3'b000};
        tbl[1] = '{32'h0, 32'h0, 3'b001, 4'h8, 8, 1'b1, 3'b000};
        tbl[2] = '{32'h0, 32'h0, 3'b100, 4'h7, 8, 1'b1, 3'b000};
        tbl[3] = '{32'h0, 32'h0, 3'b000, 4'h2, 8, 1'b0, 3'b010};
        tbl[4] = '{32'h0, 32'h0, 3'b000, 4'h0, 7, 1'b0, 3'b100};
        tbl[5] = '{32'h0, 32'h0, 3'b000, 4'h0, 9, 1'b0, 3'b100};
        tbl[6] = '{32'h0, 32'h0, 3'b000, 4'hB, 8, 1'b1, 3'b000};
        tbl[7] = '{32'h0, 32'h0, 3'b010, 4'hD, 8, 1'b0, 3'b001};
        tbl[8] = '{32'h12345678, 32'h9ABCDEF0, 3'b101,
                   crc_model({32'h12345678, 32'h9ABCDEF0, 1'b1, 3'b101}), 8, 1'b1, 3'b000};

        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err_valid", err_valid, 0);
        chk("rst_err_flags", err_flags, 0);
        chk("rst_a", a_out, 0);
        chk("rst_b", b_out, 0);
        chk("rst_op", op_out, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            send_pkt(tbl[i].b, tbl[i].a, tbl[i].op, tbl[i].crc, tbl[i].nd, 0);
            check_pkt(tbl[i].ev, tbl[i].ef, tbl[i].b, tbl[i].a, tbl[i].op);
        end

        send_frame(1'b0, 8'h3C, 1'b0);
        check_pkt(1'b0, 3'b100, 0, 0, 0);
        send_pkt(tbl[8].b, tbl[8].a, tbl[8].op, tbl[8].crc, 8, 1);
        check_pkt(1'b1, 3'b000, tbl[8].b, tbl[8].a, tbl[8].op);

        // abort mid-byte-5 with reset; the partial packet must vanish
        for (int k = 0; k < 4; k++) send_frame(1'b0, 8'hFF, 1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        sin = 1'b1;
        #1;
        chk("midrst_a", a_out, 0);
        chk("midrst_b", b_out, 0);
        chk("midrst_op", op_out, 0);
        chk("midrst_valid", {out_valid, err_valid}, 0);
        last_a = '0;
        last_b = '0;
        last_op = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_pkt(32'h0FFFFFFF, 32'h00005577, 3'b001, crc_model({32'h0FFFFFFF, 32'h00005577, 1'b1, 3'b001}), 8, 0);
        check_pkt(1'b1, 3'b000, 32'h0FFFFFFF, 32'h00005577, 3'b001);

        for (int n = 0; n < 400; n++) begin
            rb = $urandom;
            ra = $urandom;
            mode = $urandom_range(0, 9);
            rnd = 8;
            case ($urandom_range(0, 3))
                0: rop = 3'b000;
                1: rop = 3'b001;
                2: rop = 3'b100;
                default: rop = 3'b101;
            endcase
            if (mode == 0) rnd = ($urandom_range(0, 1) == 0) ? 7 : 9;
            if (mode == 2) rop = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'b111;
            rcrc = crc_model({rb, ra, 1'b1, rop});
            if (mode == 1) rcrc = rcrc ^ 4'($urandom_range(1, 15));
            model(rb, ra, rop, rcrc, rnd, ev, ef);
            send_pkt(rb, ra, rop, rcrc, rnd, 2);
            check_pkt(ev, ef, rb, ra, rop);
        end

        chk("pulse_count", pulses, exp_pulses);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
